mem_load_resp_queue: RTL and testbench

//  Parametrised load-response buffer for the memory stage; successor to the single-entry data_rd_buff scheme.

---
 rtl/mem_load_resp_queue.sv | 145 ++++++++++++++
 tb/tb_mem_load_resp_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_resp_queue.sv
// In-order load-response queue: tracks outstanding dcache loads, extends each response and hands it to WB.
// Build option MEM_RESP_BYPASS_EN forwards a response aimed at the empty head straight to out_data.
module mem_load_resp_queue #(
  parameter int DEPTH  = 4,
  parameter int DEST_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_size,
  input  logic                       req_sign,
  input  logic [1:0]                 req_off,
  input  logic [DEST_W-1:0]          req_dest,
  input  logic                       resp_ok,
  input  logic [31:0]                resp_rdata,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [DEST_W-1:0]          out_dest,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     discard_cnt,
  output logic                       proto_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr, rsp_ptr, rd_ptr;
  logic [CW-1:0]     count_q, pend_q, discard_q;
  logic              err_q;
  logic [DEPTH-1:0]  e_valid, e_has;
  logic [1:0]        e_size [DEPTH];
  logic              e_sign [DEPTH];
  logic [1:0]        e_off  [DEPTH];
  logic [DEST_W-1:0] e_dest [DEPTH];
  logic [31:0]       e_data [DEPTH];

  function automatic logic [31:0] extract(input logic [1:0] size, input logic sign,
                                          input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'd0:    extract = sign ? {{24{b[7]}}, b} : {24'b0, b};
      2'd1:    extract = sign ? {{16{h[15]}}, h} : {16'b0, h};
      default: extract = rdata;
    endcase
  endfunction

  logic        acc, disc_hit, live_hit, stray, pop, byp;
  logic [31:0] rsp_val;
  logic [CW:0] disc_sum;

  assign req_ready = (count_q < CW'(DEPTH));
  assign acc       = req_valid && req_ready && !flush;
  // Pending discards belong to older, flushed loads, so they always drain first.
  assign disc_hit  = resp_ok && (discard_q != '0);
  assign live_hit  = resp_ok && !disc_hit && (pend_q != '0);
  assign stray     = resp_ok && !disc_hit && !live_hit;
  assign rsp_val   = extract(e_size[rsp_ptr], e_sign[rsp_ptr], e_off[rsp_ptr], resp_rdata);

`ifdef MEM_RESP_BYPASS_EN
  assign byp = live_hit && e_valid[rd_ptr] && !e_has[rd_ptr] && (rsp_ptr == rd_ptr);
`else
  assign byp = 1'b0;
`endif

  assign out_valid   = (e_valid[rd_ptr] && e_has[rd_ptr]) || byp;
  assign out_data    = !out_valid ? 32'b0 : (byp ? rsp_val : e_data[rd_ptr]);
  assign out_dest    = out_valid ? e_dest[rd_ptr] : '0;
  assign pop         = out_valid && out_ready && !flush;
  assign count       = count_q;
  assign discard_cnt = discard_q;
  assign proto_err   = err_q;

  // Responses still owed after a flush: old discards plus unanswered loads, minus this cycle's beat.
  always_comb begin
    disc_sum = {1'b0, discard_q} + {1'b0, pend_q};
    if (disc_hit || live_hit) disc_sum = disc_sum - (CW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rsp_ptr   <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      discard_q <= '0;
      err_q     <= 1'b0;
      e_valid   <= '0;
      e_has     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_size[i] <= '0;
        e_sign[i] <= 1'b0;
        e_off[i]  <= '0;
        e_dest[i] <= '0;
        e_data[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rsp_ptr <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      e_valid <= '0;
      e_has   <= '0;
      if (disc_sum > (CW+1)'(DEPTH)) begin
        discard_q <= CW'(DEPTH);
        err_q     <= 1'b1;
      end else begin
        discard_q <= disc_sum[CW-1:0];
      end
      if (stray) err_q <= 1'b1;
    end else begin
      if (acc) begin
        e_valid[wr_ptr] <= 1'b1;
        e_has[wr_ptr]   <= 1'b0;
        e_size[wr_ptr]  <= req_size;
        e_sign[wr_ptr]  <= req_sign;
        e_off[wr_ptr]   <= req_off;
        e_dest[wr_ptr]  <= req_dest;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (disc_hit) discard_q <= discard_q - CW'(1);
      if (live_hit) begin
        rsp_ptr <= rsp_ptr + PW'(1);
        if (!(byp && pop)) begin
          e_has[rsp_ptr]  <= 1'b1;
          e_data[rsp_ptr] <= rsp_val;
        end
      end
      if (stray) err_q <= 1'b1;
      if (pop) begin
        e_valid[rd_ptr] <= 1'b0;
        e_has[rd_ptr]   <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      count_q <= count_q + CW'(acc) - CW'(pop);
      pend_q  <= pend_q + CW'(acc) - CW'(live_hit);
    end
  end
endmodule

// File: tb/tb_mem_load_resp_queue.sv
// Self-checking bench for mem_load_resp_queue: extraction table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_mem_load_resp_queue;
  localparam int DEPTH  = 4;
  localparam int DEST_W = 5;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset, req_valid, req_sign, resp_ok, flush, out_ready;
  logic [1:0]        req_size, req_off;
  logic [DEST_W-1:0] req_dest;
  logic [31:0]       resp_rdata;
  logic              req_ready, out_valid, proto_err;
  logic [31:0]       out_data;
  logic [DEST_W-1:0] out_dest;
  logic [CW-1:0]     count, discard_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_load_resp_queue #(.DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_size(req_size), .req_sign(req_sign), .req_off(req_off), .req_dest(req_dest),
    .resp_ok(resp_ok), .resp_rdata(resp_rdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
    .count(count), .discard_cnt(discard_cnt), .proto_err(proto_err)
  );

  typedef struct {
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [DEST_W-1:0] dest;
    int                size;
    bit                sign;
    int                off;
    bit                has;
    logic [31:0]       data;
  } ent_t;

  vec_t vt [11];
  ent_t mq [$];
  int   md;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_size = 0; req_sign = 0; req_off = 0; req_dest = 0;
    resp_ok = 0; resp_rdata = 0; flush = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_dest"}, out_dest, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_discard"}, discard_cnt, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  task automatic issue(input logic [1:0] size, input logic sign, input logic [1:0] off, input int dest);
    req_valid = 1; req_size = size; req_sign = sign; req_off = off; req_dest = DEST_W'(dest);
    step();
    req_valid = 0;
  endtask

  task automatic respond(input logic [31:0] rd);
    resp_ok = 1; resp_rdata = rd;
    step();
    resp_ok = 0;
  endtask

  // Reference extraction by shift-and-mask arithmetic.
  function automatic logic [31:0] ref_ext(input int size, input bit sign, input int off, input logic [31:0] rd);
    int bits;
    longint v;
    if (size == 0) begin
      bits = 8;
      v = longint'((rd >> (8 * off)) & 32'hFF);
    end else if (size == 1) begin
      bits = 16;
      v = longint'((rd >> (16 * (off / 2))) & 32'hFFFF);
    end else begin
      return rd;
    end
    if (sign && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  initial begin
    vt[0]  = '{2'd0, 1'b1, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80};
    vt[1]  = '{2'd1, 1'b0, 2'd2, 32'hBEEF_0001, 32'h0000_BEEF};
    vt[2]  = '{2'd0, 1'b0, 2'd3, 32'h80FF_1234, 32'h0000_0080};
    vt[3]  = '{2'd0, 1'b1, 2'd0, 32'h0000_007F, 32'h0000_007F};
    vt[4]  = '{2'd0, 1'b1, 2'd1, 32'h0000_9A00, 32'hFFFF_FF9A};
    vt[5]  = '{2'd1, 1'b1, 2'd0, 32'h1234_8001, 32'hFFFF_8001};
    vt[6]  = '{2'd1, 1'b1, 2'd3, 32'h8001_1234, 32'hFFFF_8001};
    vt[7]  = '{2'd1, 1'b1, 2'd1, 32'h0000_F00D, 32'hFFFF_F00D};
    vt[8]  = '{2'd2, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[9]  = '{2'd3, 1'b1, 2'd2, 32'h1357_9BDF, 32'h1357_9BDF};
    vt[10] = '{2'd0, 1'b0, 2'd2, 32'h00AB_0000, 32'h0000_00AB};

    do_reset();
    chk_reset_outputs("reset");

    // Extraction table, one load at a time.
    for (int i = 0; i < 11; i++) begin
      issue(vt[i].size, vt[i].sign, vt[i].off, i + 1);
      resp_ok = 1; resp_rdata = vt[i].rdata;
      #1;
`ifdef MEM_RESP_BYPASS_EN
      chk("tbl_resp_cycle_valid", out_valid, 1);
`else
      chk("tbl_resp_cycle_valid", out_valid, 0);
`endif
      step();
      resp_ok = 0;
      chk("tbl_valid", out_valid, 1);
      chk("tbl_data", out_data, vt[i].exp);
      chk("tbl_dest", out_dest, i + 1);
      out_ready = 1;
      step();
      out_ready = 0;
      chk("tbl_count_after_pop", count, 0);
    end

    // Fill, respond, then drain in order; a request while full waits one cycle.
    do_reset();
    for (int i = 0; i < 4; i++) issue(2'd2, 1'b0, 2'd0, 10 + i);
    chk("full_count", count, 4);
    chk("full_req_ready", req_ready, 0);
    chk("full_out_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) respond(32'h1000_0000 + i);
    chk("full_head_valid", out_valid, 1);
    out_ready = 1; req_valid = 1; req_size = 2'd2; req_sign = 0; req_off = 0; req_dest = 20;
    chk("drain0_data", out_data, 32'h1000_0000);
    chk("drain0_dest", out_dest, 10);
    step();
    chk("full_pop_no_accept", count, 3);
    chk("drain1_req_ready", req_ready, 1);
    chk("drain1_data", out_data, 32'h1000_0001);
    chk("drain1_dest", out_dest, 11);
    step();
    req_valid = 0;
    chk("accept_and_pop_count", count, 3);
    chk("drain2_data", out_data, 32'h1000_0002);
    chk("drain2_dest", out_dest, 12);
    step();
    chk("drain3_data", out_data, 32'h1000_0003);
    chk("drain3_dest", out_dest, 13);
    step();
    chk("late_head_waiting", out_valid, 0);
    chk("late_count", count, 1);
    respond(32'h0000_CAFE);
    chk("late_valid", out_valid, 1);
    chk("late_data", out_data, 32'h0000_CAFE);
    chk("late_dest", out_dest, 20);
    step();
    out_ready = 0;
    chk("drained_count", count, 0);

    // Flush with one of three answered; a same-cycle request is not accepted.
    do_reset();
    for (int i = 0; i < 3; i++) issue(2'd0, 1'b0, 2'd0, 1 + i);
    respond(32'h0000_0011);
    flush = 1; req_valid = 1; req_size = 2'd2; req_dest = 9;
    chk("flush_cycle_valid", out_valid, 1);
    out_ready = 1;
    step();
    flush = 0; req_valid = 0; out_ready = 0;
    chk("flush_count", count, 0);
    chk("flush_discard", discard_cnt, 2);
    chk("flush_out_valid", out_valid, 0);
    respond(32'hFFFF_FFFF);
    chk("discard1", discard_cnt, 1);
    respond(32'hFFFF_FFFF);
    chk("discard0", discard_cnt, 0);
    chk("discard_no_valid", out_valid, 0);
    chk("discard_no_err", proto_err, 0);
    issue(2'd2, 1'b0, 2'd0, 7);
    respond(32'h1234_5678);
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_data", out_data, 32'h1234_5678);
    chk("post_flush_dest", out_dest, 7);

    // Unexpected response.
    do_reset();
    respond(32'h5555_5555);
    chk("stray_err", proto_err, 1);
    chk("stray_valid", out_valid, 0);
    step(); step();
    chk("stray_err_sticky", proto_err, 1);

    // Reset with two loads outstanding.
    do_reset();
    issue(2'd2, 1'b0, 2'd0, 3);
    issue(2'd2, 1'b0, 2'd0, 4);
    reset = 1;
    step();
    reset = 0;
    chk_reset_outputs("mid_reset");
    respond(32'h0000_0001);
    chk("late_resp_err", proto_err, 1);

    // Randomized traffic against the queue model.
    do_reset();
    md = 0;
    mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int  pend;
      bit  exp_valid, acc, pop, live, disc;
      ent_t e;
      exp_valid = (mq.size() > 0) && mq[0].has;
      chk("rnd_out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("rnd_out_data", out_data, mq[0].data);
        chk("rnd_out_dest", out_dest, mq[0].dest);
      end
      chk("rnd_count", count, mq.size());
      chk("rnd_discard", discard_cnt, md);
      chk("rnd_req_ready", req_ready, mq.size() < DEPTH);
      chk("rnd_proto_err", proto_err, 0);

      pend = 0;
      foreach (mq[i]) if (!mq[i].has) pend++;
      flush      = ($urandom_range(0, 19) == 0);
      req_valid  = ((md + mq.size() < DEPTH) || (mq.size() == DEPTH)) && ($urandom_range(0, 1) == 1);
      req_size   = 2'($urandom_range(0, 3));
      req_sign   = 1'($urandom_range(0, 1));
      req_off    = 2'($urandom_range(0, 3));
      req_dest   = DEST_W'($urandom);
      resp_ok    = ((pend > 0) || (md > 0)) && ($urandom_range(0, 2) != 0);
      resp_rdata = $urandom;
      out_ready  = ($urandom_range(0, 2) != 0);

      acc  = req_valid && (mq.size() < DEPTH) && !flush;
      pop  = exp_valid && out_ready && !flush;
      disc = resp_ok && (md > 0);
      live = resp_ok && (md == 0) && (pend > 0);
      if (disc) md--;
      if (live) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].has) begin
            mq[i].has  = 1;
            mq[i].data = ref_ext(mq[i].size, mq[i].sign, mq[i].off, resp_rdata);
            break;
          end
        end
      end
      if (flush) begin
        md += pend - (live ? 1 : 0);
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (acc) begin
          e.dest = req_dest; e.size = int'(req_size); e.sign = req_sign;
          e.off = int'(req_off); e.has = 0; e.data = 0;
          mq.push_back(e);
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
